// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with a registered one-hot grant that feeds the 4-to-2 encoder.
// Define ARB_TIMEOUT_EN to add a hold counter that force-releases a grant after MAX_HOLD cycles.
module rr_arbiter4 #(
   parameter int MAX_HOLD = 15,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   input  logic       done,
   output logic [3:0] grant,
   output logic       grant_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state, state_n;
   logic [1:0] ptr, ptr_n;
   logic [1:0] sel, idx, gidx;
   logic       found;
   logic [3:0] grant_n;
   logic       release_req;

`ifdef ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt, cnt_n;
   logic             timeout_q, timeout_n;
   logic             hold_expired;

   assign hold_expired = (cnt == CNT_W'(MAX_HOLD - 1));
   assign timeout      = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign grant_valid = |grant;

   // First requester found searching upward from ptr, wrapping modulo 4.
   always_comb begin
      sel   = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      case (grant)
         4'b0010: gidx = 2'd1;
         4'b0100: gidx = 2'd2;
         4'b1000: gidx = 2'd3;
         default: gidx = 2'd0;
      endcase
   end

   always_comb begin
      state_n     = state;
      grant_n     = grant;
      ptr_n       = ptr;
      release_req = done || ((req & grant) == 4'b0000);
`ifdef ARB_TIMEOUT_EN
      cnt_n       = cnt;
      timeout_n   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (|req) begin
               grant_n = 4'b0001 << sel;
               state_n = GRANT;
`ifdef ARB_TIMEOUT_EN
               cnt_n   = '0;
`endif
            end
         end
         GRANT: begin
            // A release always passes through IDLE, so the encoder never sees a direct switch.
            if (release_req) begin
               grant_n = 4'b0000;
               ptr_n   = gidx + 2'd1;
               state_n = IDLE;
            end
`ifdef ARB_TIMEOUT_EN
            else if (hold_expired) begin
               grant_n   = 4'b0000;
               ptr_n     = gidx + 2'd1;
               state_n   = IDLE;
               timeout_n = 1'b1;
            end else if (cnt < CNT_W'(MAX_HOLD)) begin
               cnt_n = cnt + 1'b1;
            end
`endif
         end
         default: begin
            state_n = IDLE;
            grant_n = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= 4'b0000;
         ptr       <= 2'd0;
`ifdef ARB_TIMEOUT_EN
         cnt       <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state     <= state_n;
         grant     <= grant_n;
         ptr       <= ptr_n;
`ifdef ARB_TIMEOUT_EN
         cnt       <= cnt_n;
         timeout_q <= timeout_n;
`endif
      end
   end

endmodule
